// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module : mips_pkg
// Brief  : Shared opcode/funct encodings, ALU operation enum and the decoded
//          control bundle for the single-cycle MIPS core.
// Rev    : 1.0  initial release
// ============================================================================
package mips_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_R     = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR,
    ALU_SLT, ALU_SLL, ALU_SRL, ALU_LUI
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;    // commit a register result
    logic    reg_dst;      // destination is rd (else rt)
    logic    alu_src_imm;  // ALU operand B is the immediate
    logic    zero_ext;     // immediate is zero-extended
    logic    mem_write;
    logic    mem_to_reg;
    logic    branch_eq;
    logic    branch_ne;
    logic    jump;         // j / jal
    logic    link;         // jal: write pc+4 to $31
    logic    jump_reg;     // jr
    alu_op_e alu_op;
  } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/mips_if.sv
`default_nettype none
// ============================================================================
// Module : mips_if
// Brief  : Register-file access bus: two read ports and one write port.
//          master = datapath, slave = register file.
// Rev    : 1.0  initial release
// ============================================================================
interface mips_if;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;

  modport master (output ra1, ra2, we, wa, wd, input rd1, rd2);
  modport slave  (input ra1, ra2, we, wa, wd, output rd1, rd2);
endinterface
`default_nettype wire

// File: rtl/mips_reg_file.sv
`default_nettype none
// ============================================================================
// Module : reg_file
// Brief  : 32 x 32-bit register file, two asynchronous reads, one write on
//          the rising clock edge. $0 is hard-wired to zero.
// Ports  : clk - clock; bus - mips_if.slave register access bus
// Rev    : 1.0  initial release
// ============================================================================
module reg_file (
  input logic   clk,
  mips_if.slave bus
);
  logic [31:0] Registers [0:31];

  always_ff @(posedge clk) begin
    if (bus.we && (bus.wa != 5'd0)) begin
      Registers[bus.wa] <= bus.wd;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write is visible next cycle.
  assign bus.rd1 = (bus.ra1 == 5'd0) ? 32'd0 : Registers[bus.ra1];
  assign bus.rd2 = (bus.ra2 == 5'd0) ? 32'd0 : Registers[bus.ra2];
endmodule
`default_nettype wire

// File: rtl/mips_units.sv
`default_nettype none
// ============================================================================
// Module : pc_reg / instr_mem / data_mem / alu / control
// Brief  : Datapath building blocks of the single-cycle MIPS core.
//          pc_reg    - PC register (OUT), synchronous reset to 0
//          instr_mem - word-indexed asynchronous instruction ROM
//          data_mem  - word-indexed data RAM, async read, clocked write
//          alu       - 32-bit ALU selected by alu_op_e
//          control   - combinational opcode/funct decoder
// Rev    : 1.0  initial release
// ============================================================================
module pc_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc,
  output logic [31:0] OUT
);
  always_ff @(posedge clk) begin
    if (rst) OUT <= 32'd0;
    else     OUT <= next_pc;
  end
endmodule

// Depth must be a power of two so the low index bits give modulo wrap.
module instr_mem #(
  parameter int WORDS = 256
) (
  input  logic [$clog2(WORDS)-1:0] addr,
  output logic [31:0]              instr
);
  logic [31:0] InstructionMemory [0:WORDS-1];
  assign instr = InstructionMemory[addr];
endmodule

module data_mem #(
  parameter int WORDS = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(WORDS)-1:0] addr,
  input  logic [31:0]              wd,
  output logic [31:0]              rd
);
  logic [31:0] mem [0:WORDS-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wd;
  end

  assign rd = mem[addr];
endmodule

module alu import mips_pkg::*; (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  input  alu_op_e     op,
  output logic [31:0] y
);
  always_comb begin
    y = 32'd0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_NOR: y = ~(a | b);
      ALU_SLT: y = {31'd0, ($signed(a) < $signed(b))};
      ALU_SLL: y = b << shamt;
      ALU_SRL: y = b >> shamt;
      ALU_LUI: y = {b[15:0], 16'd0};
      default: y = 32'd0;
    endcase
  end
endmodule

module control import mips_pkg::*; (
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ctrl_t      ctrl
);
  // Anything not matched below leaves every strobe low: a NOP that just
  // advances to pc+4.
  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: ctrl.alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: ctrl.alu_op = ALU_SUB;
          FN_AND:          ctrl.alu_op = ALU_AND;
          FN_OR:           ctrl.alu_op = ALU_OR;
          FN_NOR:          ctrl.alu_op = ALU_NOR;
          FN_SLT:          ctrl.alu_op = ALU_SLT;
          FN_SLL:          ctrl.alu_op = ALU_SLL;
          FN_SRL:          ctrl.alu_op = ALU_SRL;
          FN_JR: begin
            ctrl.reg_write = 1'b0;
            ctrl.reg_dst   = 1'b0;
            ctrl.jump_reg  = 1'b1;
          end
          default: begin
            ctrl.reg_write = 1'b0;
            ctrl.reg_dst   = 1'b0;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        ctrl.reg_write = 1'b1; ctrl.alu_src_imm = 1'b1;
      end
      OP_SLTI: begin
        ctrl.reg_write = 1'b1; ctrl.alu_src_imm = 1'b1; ctrl.alu_op = ALU_SLT;
      end
      OP_ANDI: begin
        ctrl.reg_write = 1'b1; ctrl.alu_src_imm = 1'b1; ctrl.zero_ext = 1'b1;
        ctrl.alu_op = ALU_AND;
      end
      OP_ORI: begin
        ctrl.reg_write = 1'b1; ctrl.alu_src_imm = 1'b1; ctrl.zero_ext = 1'b1;
        ctrl.alu_op = ALU_OR;
      end
      OP_LUI: begin
        ctrl.reg_write = 1'b1; ctrl.alu_src_imm = 1'b1; ctrl.alu_op = ALU_LUI;
      end
      OP_LW: begin
        ctrl.reg_write = 1'b1; ctrl.alu_src_imm = 1'b1; ctrl.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1; ctrl.alu_src_imm = 1'b1;
      end
      OP_BEQ:  ctrl.branch_eq = 1'b1;
      OP_BNE:  ctrl.branch_ne = 1'b1;
      OP_J:    ctrl.jump = 1'b1;
      OP_JAL: begin
        ctrl.jump = 1'b1; ctrl.link = 1'b1; ctrl.reg_write = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end
endmodule
`default_nettype wire

// File: rtl/mips.sv
`default_nettype none
// ============================================================================
// Module : mips
// Brief  : Single-cycle 32-bit MIPS core; one instruction per clock from an
//          internal instruction memory, 32-entry register file, internal
//          data memory. IMEM_WORDS/DMEM_WORDS must be powers of two.
// Ports  : clk - rising-edge clock; rst - synchronous active-high reset;
//          pc  - current program counter (byte address)
// Rev    : 1.0  initial release
// ============================================================================
module mips import mips_pkg::*; #(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc
);
  localparam int IW = $clog2(IMEM_WORDS);
  localparam int DW = $clog2(DMEM_WORDS);

  logic [31:0] instr, pc_plus4, next_pc, imm_ext, alu_b, alu_y, mem_rd;
  logic [31:0] branch_target, jump_target;
  logic        take_branch;
  ctrl_t       ctrl;

  mips_if rf_bus ();

  pc_reg ProgCounter (.clk(clk), .rst(rst), .next_pc(next_pc), .OUT(pc));

  instr_mem #(.WORDS(IMEM_WORDS)) IM (.addr(pc[IW+1:2]), .instr(instr));

  control ctrl_dec (.opcode(instr[31:26]), .funct(instr[5:0]), .ctrl(ctrl));

  reg_file RF (.clk(clk), .bus(rf_bus));

  assign imm_ext = ctrl.zero_ext ? {16'd0, instr[15:0]}
                                 : {{16{instr[15]}}, instr[15:0]};
  assign alu_b   = ctrl.alu_src_imm ? imm_ext : rf_bus.rd2;

  alu u_alu (.a(rf_bus.rd1), .b(alu_b), .shamt(instr[10:6]), .op(ctrl.alu_op), .y(alu_y));

  // Nothing may commit while reset is held, so both write strobes are gated.
  data_mem #(.WORDS(DMEM_WORDS)) u_dmem (
    .clk(clk), .we(ctrl.mem_write & ~rst), .addr(alu_y[DW+1:2]),
    .wd(rf_bus.rd2), .rd(mem_rd)
  );

  assign rf_bus.ra1 = instr[25:21];
  assign rf_bus.ra2 = instr[20:16];
  assign rf_bus.we  = ctrl.reg_write & ~rst;
  assign rf_bus.wa  = ctrl.link ? 5'd31 : (ctrl.reg_dst ? instr[15:11] : instr[20:16]);
  assign rf_bus.wd  = ctrl.link ? pc_plus4 : (ctrl.mem_to_reg ? mem_rd : alu_y);

  assign pc_plus4      = pc + 32'd4;
  assign branch_target = pc_plus4 + (imm_ext << 2);
  assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};
  assign take_branch   = (ctrl.branch_eq &  (rf_bus.rd1 == rf_bus.rd2))
                       | (ctrl.branch_ne & ~(rf_bus.rd1 == rf_bus.rd2));

  always_comb begin
    next_pc = pc_plus4;
    if (ctrl.jump_reg)  next_pc = rf_bus.rd1;
    else if (ctrl.jump) next_pc = jump_target;
    else if (take_branch) next_pc = branch_target;
  end
endmodule
`default_nettype wire

// File: tb/tb_mips.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_mips
// Brief  : Directed programs for the single-cycle MIPS core with hand-computed
//          expected register / PC values.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mips;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc;
  int          checks   = 0;
  int          failures = 0;

  mips #(.IMEM_WORDS(256), .DMEM_WORDS(256)) dut (.clk(clk), .rst(rst), .pc(pc));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] addr);
    return {op, addr};
  endfunction

  // Hold reset and fill the instruction memory with NOPs.
  task automatic begin_prog();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 256; i++) dut.IM.InstructionMemory[i] = 32'd0;
  endtask

  task automatic put(input int idx, input logic [31:0] w);
    dut.IM.InstructionMemory[idx] = w;
  endtask

  // Two reset edges, then release.
  task automatic end_reset();
    repeat (2) @(negedge clk);
    check("reset_pc", pc, 32'd0);
    rst = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] rg(input int n);
    return dut.RF.Registers[n];
  endfunction

  initial begin
    // Reset, then three NOPs
    begin_prog();
    end_reset();
    run(3);
    check("nop_pc", pc, 32'h0000_000C);

    // ALU program
    begin_prog();
    put(0,  enc_i(6'd8, 5'd0, 5'd8, 16'd5));           // addi t0,$0,5
    put(1,  enc_i(6'd8, 5'd0, 5'd9, 16'hFFFD));        // addi t1,$0,-3
    put(2,  enc_r(5'd8, 5'd9, 5'd10, 5'd0, 6'h20));    // add  t2,t0,t1
    put(3,  enc_r(5'd9, 5'd8, 5'd11, 5'd0, 6'h2A));    // slt  t3,t1,t0
    put(4,  enc_i(6'd13, 5'd0, 5'd12, 16'hFFFF));      // ori  t4,$0,0xFFFF
    put(5,  enc_i(6'd15, 5'd0, 5'd13, 16'h8000));      // lui  t5,0x8000
    put(6,  enc_r(5'd0, 5'd13, 5'd14, 5'd4, 6'h02));   // srl  t6,t5,4
    put(7,  enc_r(5'd0, 5'd8, 5'd15, 5'd3, 6'h00));    // sll  t7,t0,3
    put(8,  enc_r(5'd8, 5'd0, 5'd17, 5'd0, 6'h27));    // nor  s1,t0,$0
    put(9,  enc_r(5'd9, 5'd8, 5'd18, 5'd0, 6'h22));    // sub  s2,t1,t0
    put(10, enc_i(6'd10, 5'd9, 5'd19, 16'hFFFE));      // slti s3,t1,-2
    put(11, enc_i(6'd12, 5'd9, 5'd20, 16'h8000));      // andi s4,t1,0x8000
    put(12, enc_i(6'd8, 5'd13, 5'd21, 16'hFFFF));      // addi s5,t5,-1
    end_reset();
    run(13);
    check("add_t2",  rg(10), 32'h0000_0002);
    check("slt_t3",  rg(11), 32'h0000_0001);
    check("ori_t4",  rg(12), 32'h0000_FFFF);
    check("lui_t5",  rg(13), 32'h8000_0000);
    check("srl_t6",  rg(14), 32'h0800_0000);
    check("sll_t7",  rg(15), 32'h0000_0028);
    check("nor_s1",  rg(17), 32'hFFFF_FFFA);
    check("sub_s2",  rg(18), 32'hFFFF_FFF8);
    check("slti_s3", rg(19), 32'h0000_0001);
    check("andi_s4", rg(20), 32'h0000_8000);
    check("wrap_s5", rg(21), 32'h7FFF_FFFF);
    check("alu_pc",  pc,     32'h0000_0034);

    // Reset mid-program: the instruction at 0 is presented but must not commit
    begin_prog();
    put(0, enc_i(6'd8, 5'd0, 5'd13, 16'd77));          // addi t5,$0,77
    end_reset();
    check("rst_nowrite", rg(13), 32'h8000_0000);
    run(1);
    check("rst_restart", rg(13), 32'd77);

    // Memory
    begin_prog();
    put(0, enc_i(6'd8,  5'd0, 5'd8,  16'h1234));       // addi t0,$0,0x1234
    put(1, enc_i(6'd43, 5'd0, 5'd8,  16'd8));          // sw   t0,8($0)
    put(2, enc_i(6'd35, 5'd0, 5'd16, 16'd8));          // lw   s0,8($0)
    put(3, enc_i(6'd8,  5'd0, 5'd9,  16'h0055));       // addi t1,$0,0x55
    put(4, enc_i(6'd43, 5'd0, 5'd9,  16'd1036));       // sw   t1,1036($0) -> word 3
    put(5, enc_i(6'd35, 5'd0, 5'd17, 16'd12));         // lw   s1,12($0)
    end_reset();
    run(6);
    check("lw_s0",     rg(16), 32'h0000_1234);
    check("dwrap_s1",  rg(17), 32'h0000_0055);

    // Decrement-by-2 loop with slt guard, halting on a self-jump
    begin_prog();
    put(0, enc_i(6'd8, 5'd0, 5'd8, 16'd7));            // addi t0,$0,7
    put(1, enc_i(6'd8, 5'd8, 5'd8, 16'hFFFE));         // addi t0,t0,-2
    put(2, enc_r(5'd8, 5'd0, 5'd9, 5'd0, 6'h2A));      // slt  t1,t0,$0
    put(3, enc_i(6'd4, 5'd9, 5'd0, 16'hFFFD));         // beq  t1,$0,loop
    put(4, enc_j(6'd2, 26'd4));                        // j    self
    end_reset();
    run(40);
    check("loop_t0",  rg(8), 32'hFFFF_FFFF);
    check("halt_pc",  pc,    32'h0000_0010);
    run(7);
    check("halt_pc2", pc,    32'h0000_0010);

    // Jumps and branches
    begin_prog();
    put(0,  enc_j(6'd3, 26'h10));                      // jal  0x40
    put(16, enc_r(5'd31, 5'd0, 5'd0, 5'd0, 6'h08));    // jr   $ra
    put(1,  enc_i(6'd5, 5'd31, 5'd0, 16'd2));          // bne  $ra,$0,+2 (taken)
    put(4,  enc_i(6'd4, 5'd31, 5'd0, 16'd5));          // beq  $ra,$0,+5 (not taken)
    end_reset();
    run(1);
    check("jal_ra", rg(31), 32'h0000_0004);
    check("jal_pc", pc,     32'h0000_0040);
    run(1);
    check("jr_pc",  pc,     32'h0000_0004);
    run(1);
    check("bne_pc", pc,     32'h0000_0010);
    run(1);
    check("beq_nt_pc", pc,  32'h0000_0014);

    // Unknown encodings and $0 protection
    begin_prog();
    put(0, enc_i(6'd8, 5'd0, 5'd14, 16'h0111));        // addi t6,$0,0x111
    put(1, enc_i(6'd8, 5'd0, 5'd15, 16'h0222));        // addi t7,$0,0x222
    put(2, enc_i(6'h3F, 5'd0, 5'd14, 16'h1234));       // unknown opcode, rt=t6
    put(3, enc_r(5'd0, 5'd0, 5'd15, 5'd0, 6'h3F));     // unknown funct, rd=t7
    put(4, enc_i(6'd8, 5'd0, 5'd0, 16'd9));            // addi $0,$0,9
    put(5, enc_i(6'd8, 5'd0, 5'd13, 16'd1));           // addi t5,$0,1
    put(6, enc_r(5'd0, 5'd0, 5'd16, 5'd0, 6'h20));     // add  s0,$0,$0
    end_reset();
    run(7);
    check("unk_op_t6", rg(14), 32'h0000_0111);
    check("unk_fn_t7", rg(15), 32'h0000_0222);
    check("zero_t5",   rg(13), 32'h0000_0001);
    check("zero_s0",   rg(16), 32'h0000_0000);
    check("unk_pc",    pc,     32'h0000_001C);

    // PC beyond instruction memory depth wraps onto low words
    begin_prog();
    put(0, enc_i(6'd8, 5'd13, 5'd13, 16'd1));          // addi t5,t5,1
    put(1, enc_j(6'd2, 26'h100));                      // j    0x400
    end_reset();
    run(2);
    check("iwrap_pc", pc,     32'h0000_0400);
    check("iwrap_t5", rg(13), 32'h0000_0002);
    run(1);
    check("iwrap_pc2", pc,     32'h0000_0404);
    check("iwrap_t5b", rg(13), 32'h0000_0003);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
